fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the single write port of the asynchronous FIFO among N_REQ requesters in the write-clock domain.
- Uses round-robin arbitration with bounded bursts.
- Drives the FIFO's w_enable/w_data, honours w_full, and releases a stalled owner after a timeout.
- Counts FIFO write_error pulses for debug.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- A_SIZE, 8, data word width; matches the FIFO data width
- MAX_BURST, 4, maximum beats per grant (>=1)
- STALL_TIMEOUT, 16, consecutive full cycles before the owner is forcibly released (>=1)
- ERR_W, 16, width of the write-error counter

Ports:
- clk  input  1  write-domain clock (same clock as the FIFO write side)
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  per-requester request; held while data is valid
- req_data  input  N_REQ*A_SIZE  packed data; requester i uses bits [i*A_SIZE +: A_SIZE]
- req_last  input  N_REQ  marks the final beat of requester i's packet
- grant  output  N_REQ  one-hot registered grant; all zero when no owner
- ack  output  N_REQ  beat accepted this cycle for requester i (combinational)
- w_full  input  1  FIFO full flag
- write_error  input  1  FIFO write-error pulse
- w_enable  output  1  FIFO write enable (combinational)
- w_data  output  A_SIZE  FIFO write data (combinational mux of the owner's slice)
- busy  output  1  high when state != IDLE
- err_count  output  ERR_W  saturating count of write_error pulses

Behaviour:
- Reset (rst high at a posedge clk) sets:
  - state=IDLE, grant=0, owner=0, rr_ptr=0
  - beat_cnt=0, stall_cnt=0, err_count=0
- While rst is high, w_enable and ack are forced to 0 combinationally.
- Reset mid-burst: the burst is abandoned with no further beats, and the requester must re-request.
- States:
  - IDLE: if |req, select the first set bit scanning from rr_ptr upward, modulo N_REQ. Register owner and grant=onehot(owner), clear beat_cnt/stall_cnt, go to BURST. Otherwise stay in IDLE.
  - BURST: w_enable = req[owner] & !w_full; w_data = owner slice; ack[owner] = w_enable.
    - Each accepted beat increments beat_cnt.
    - End of burst when an accepted beat has req_last[owner]=1, when an accepted beat makes beat_cnt==MAX_BURST, or when req[owner]==0.
    - If req[owner]=1 and w_full=1, go to HOLD with stall_cnt=1.
  - HOLD: w_enable=0, grant held.
    - If w_full drops, return to BURST next cycle with stall_cnt cleared.
    - If req[owner] drops, end of burst.
    - If stall_cnt reaches STALL_TIMEOUT, end of burst (timeout); otherwise stall_cnt increments.
- End of burst: grant<=0, rr_ptr<=(owner+1) mod N_REQ, state<=IDLE.
  - This gives one dead cycle between grants and a 1-cycle arbitration latency from req to grant.
- Requesters see the grant on the cycle after arbitration. Data must be valid whenever req is high, and a beat is consumed only when ack=1.
- The block never asserts w_enable while w_full=1, so a FIFO write_error indicates an upstream fault.
- err_count increments on every clk cycle where write_error=1 (outside reset) and saturates at all-ones.
- A single requester that is continuously requesting still gets bursts separated by one IDLE cycle. Round-robin guarantees that every active requester is granted within N_REQ arbitrations.
- Grant is never multi-hot. ack is nonzero only for the owner.

Test Plan:
- Reset, then req=4'b0001 with 3 beats, last on beat 3, w_full=0 -> grant=0001 at cycle 1, ack on cycles 1-3, w_data follows the beats, grant=0 and state IDLE at cycle 4, rr_ptr=1.
- req=4'b1111 held, no req_last, MAX_BURST=4 -> grants in order 0001, 0010, 0100, 1000, 0001, each with exactly 4 acks and 1 idle cycle between grants.
- Owner granted, w_full raised for 5 cycles mid-burst -> w_enable=0 for those 5 cycles, grant held, transfer resumes the cycle after w_full falls, no beat lost or duplicated.
- w_full held high for 20 cycles during a burst (STALL_TIMEOUT=16) -> grant released after 16 HOLD cycles, rr_ptr advances, the next requester is granted.
- rst asserted mid-burst -> on the next cycle grant=0, w_enable=0, busy=0, err_count=0; after rst deasserts, arbitration restarts at requester 0.
- Pulse write_error 3 times, then force err_count to within 1 of saturation and pulse twice -> err_count=3 after the first step, then all-ones with no wrap.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the asynchronous FIFO's single write port among
// N_REQ write-domain requesters. Grants are bounded to MAX_BURST beats, a
// stalled owner is released after STALL_TIMEOUT full cycles, and FIFO
// write_error pulses are counted (saturating) for debug.
module fifo_write_arbiter #(
    parameter int N_REQ         = 4,
    parameter int A_SIZE        = 8,
    parameter int MAX_BURST     = 4,
    parameter int STALL_TIMEOUT = 16,
    parameter int ERR_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*A_SIZE-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          ack,
    input  logic                      w_full,
    input  logic                      write_error,
    output logic                      w_enable,
    output logic [A_SIZE-1:0]         w_data,
    output logic                      busy,
    output logic [ERR_W-1:0]          err_count
);

    localparam int OW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             pickValid;
    logic [OW-1:0]    pickIdx;
    logic             ownerReq;
    logic             ownerLast;
    logic             wEnRaw;
    logic             endBurst;
    logic [BW-1:0]    beatNext;
    logic [OW-1:0]    ownerNext;

    assign ownerReq  = req[owner_q];
    assign ownerLast = req_last[owner_q];
    assign beatNext  = beat_cnt_q + BW'(1);
    assign ownerNext = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);

    // Round-robin pick: first requester at or after rr_ptr, wrapping modulo N_REQ.
    // Scanning downward lets the lowest offset from rr_ptr win the last assignment.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr_q) + k) % N_REQ]) begin
                pickValid = 1'b1;
                pickIdx   = OW'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end

    // Next-state logic for the grant FSM plus the combinational write handshake.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        wEnRaw      = 1'b0;
        endBurst    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    owner_d     = pickIdx;
                    grant_d     = N_REQ'(1) << pickIdx;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (!ownerReq) begin
                    endBurst = 1'b1;
                end else if (w_full) begin
                    state_d     = HOLD;
                    stall_cnt_d = SW'(1);
                end else begin
                    wEnRaw     = 1'b1;
                    beat_cnt_d = beatNext;
                    if (ownerLast || (beatNext == BW'(MAX_BURST))) begin
                        endBurst = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!ownerReq) begin
                    endBurst = 1'b1;
                end else if (!w_full) begin
                    state_d     = BURST;
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == SW'(STALL_TIMEOUT)) begin
                    endBurst = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt_q + SW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (endBurst) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = ownerNext;
        end
    end

    // Write port and per-requester ack; both held low while reset is asserted.
    always_comb begin
        w_enable     = wEnRaw & ~rst;
        ack          = '0;
        ack[owner_q] = w_enable;
        w_data       = req_data[owner_q*A_SIZE +: A_SIZE];
    end

    // Saturating count of FIFO write_error pulses.
    always_comb begin
        err_count_d = err_count_q;
        if (write_error && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    // FSM and arbitration state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Debug error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign err_count = err_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter. Requesters are modelled as per-port
// beat queues that advance on ack; every beat loaded is also pushed onto an
// expected-write queue (owner, data, cycle) that is popped on each FIFO write.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int A  = 8;
    localparam int MB = 4;
    localparam int ST = 16;
    localparam int EW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*A-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           w_full;
    logic           write_error;
    logic           w_enable;
    logic [A-1:0]   w_data;
    logic           busy;
    logic [EW-1:0]  err_count;

    fifo_write_arbiter #(
        .N_REQ(N), .A_SIZE(A), .MAX_BURST(MB), .STALL_TIMEOUT(ST), .ERR_W(EW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .grant(grant), .ack(ack), .w_full(w_full), .write_error(write_error),
        .w_enable(w_enable), .w_data(w_data), .busy(busy), .err_count(err_count)
    );

    // Free-running write-domain clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    typedef struct packed {
        logic [A-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [3:0]   who;
        logic [A-1:0] data;
        logic [31:0]  cyc;
    } exp_t;

    beat_t      srcQ [N][$];
    exp_t       expQ [$];
    int         nAssert = 0;
    int         nFail   = 0;
    int         cyc     = 0;
    logic [N-1:0] ackSeen;

    // One counted comparison; failures are reported and counted, never fatal here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Present each requester's head beat; req is high whenever it has data.
    task automatic driveInputs();
        for (int i = 0; i < N; i++) begin
            if (srcQ[i].size() != 0) begin
                req[i]          = 1'b1;
                req_data[i*A +: A] = srcQ[i][0].data;
                req_last[i]     = srcQ[i][0].last;
            end else begin
                req[i]          = 1'b0;
                req_data[i*A +: A] = '0;
                req_last[i]     = 1'b0;
            end
        end
    endtask

    // Load a beat for requester 'who' and record where it must appear on the FIFO port.
    task automatic pushBeat(input int who, input logic [A-1:0] d, input logic last, input int c);
        beat_t b;
        exp_t  e;
        b.data = d;
        b.last = last;
        srcQ[who].push_back(b);
        e.who  = 4'(who);
        e.data = d;
        e.cyc  = 32'(c);
        expQ.push_back(e);
    endtask

    // Mid-cycle sample of the write port against the scoreboard.
    task automatic sampleOutputs();
        exp_t e;
        @(negedge clk);
        checkOutput("noWriteWhenFull", 32'(w_enable & w_full), 32'd0);
        checkOutput("grantOneHot0", 32'($onehot0(grant)), 32'd1);
        if (w_enable) begin
            checkOutput("writeExpected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("wData", 32'(w_data), 32'(e.data));
                checkOutput("ackOwner", 32'(ack), 32'(N'(1) << e.who));
                checkOutput("grantOwner", 32'(grant), 32'(N'(1) << e.who));
                checkOutput("writeCycle", 32'(cyc), e.cyc);
            end
        end else begin
            checkOutput("ackIdle", 32'(ack), 32'd0);
        end
        ackSeen = ack;
    endtask

    // Advance one clock; requesters consume the beat that was acked.
    task automatic applyStimulus();
        beat_t tmp;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ackSeen[i] && (srcQ[i].size() != 0)) begin
                tmp = srcQ[i].pop_front();
            end
        end
        cyc++;
        driveInputs();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        sampleOutputs();
        applyStimulus();
        rst = 1'b0;
    endtask

    task automatic startTest();
        cyc = 0;
        driveInputs();
    endtask

    task automatic pulseErrors(input int n);
        write_error = 1'b1;
        repeat (n) begin
            sampleOutputs();
            applyStimulus();
        end
        write_error = 1'b0;
    endtask

    // Linear sequence of directed scenarios.
    initial begin
        rst         = 1'b1;
        w_full      = 1'b0;
        write_error = 1'b0;
        req         = '0;
        req_data    = '0;
        req_last    = '0;
        ackSeen     = '0;
        driveInputs();

        // Reset state
        sampleOutputs();
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wEnable", 32'(w_enable), 32'd0);
        checkOutput("rst_errCount", 32'(err_count), 32'd0);
        applyStimulus();
        rst = 1'b0;

        // Single requester, 3-beat packet
        $display("[TB] single requester packet");
        pushBeat(0, 8'hA1, 1'b0, 1);
        pushBeat(0, 8'hA2, 1'b0, 2);
        pushBeat(0, 8'hA3, 1'b1, 3);
        startTest();
        while (cyc < 6) begin
            sampleOutputs();
            if (cyc == 0) checkOutput("t1_grantC0", 32'(grant), 32'd0);
            if (cyc == 1) checkOutput("t1_grantC1", 32'(grant), 32'b0001);
            if (cyc == 1) checkOutput("t1_busyC1", 32'(busy), 32'd1);
            if (cyc == 4) checkOutput("t1_grantC4", 32'(grant), 32'd0);
            if (cyc == 4) checkOutput("t1_busyC4", 32'(busy), 32'd0);
            applyStimulus();
        end
        checkOutput("t1_drained", 32'(expQ.size()), 32'd0);

        // rr_ptr now 1: requester 1 wins over requester 0
        $display("[TB] round-robin pointer after first burst");
        pushBeat(1, 8'hC0, 1'b1, 1);
        pushBeat(0, 8'hB0, 1'b1, 3);
        startTest();
        while (cyc < 5) begin
            sampleOutputs();
            applyStimulus();
        end
        checkOutput("t1b_drained", 32'(expQ.size()), 32'd0);

        // All four requesting, bursts capped at MAX_BURST with one idle cycle between
        $display("[TB] four requesters, bounded bursts");
        applyReset();
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < MB; k++) begin
                pushBeat(b % N, 8'(16 * (b % N) + MB * (b / N) + k), 1'b0, 5 * b + 1 + k);
            end
        end
        startTest();
        while (cyc < 42) begin
            sampleOutputs();
            if ((cyc % 5 == 0) && (cyc < 40)) checkOutput("t2_idleGap", 32'(grant), 32'd0);
            applyStimulus();
        end
        checkOutput("t2_drained", 32'(expQ.size()), 32'd0);

        // Short stall: w_full for 5 cycles mid-burst of requester 2
        $display("[TB] short stall");
        pushBeat(2, 8'hD0, 1'b0, 1);
        pushBeat(2, 8'hD1, 1'b0, 2);
        pushBeat(2, 8'hD2, 1'b0, 9);
        pushBeat(2, 8'hD3, 1'b1, 10);
        startTest();
        while (cyc < 13) begin
            w_full = (cyc >= 3) && (cyc <= 7);
            sampleOutputs();
            if ((cyc >= 3) && (cyc <= 8)) checkOutput("t3_grantHeld", 32'(grant), 32'b0100);
            applyStimulus();
        end
        w_full = 1'b0;
        checkOutput("t3_drained", 32'(expQ.size()), 32'd0);

        // Long stall: owner 3 released after STALL_TIMEOUT hold cycles
        $display("[TB] stall timeout");
        pushBeat(3, 8'hE0, 1'b0, 1);
        pushBeat(0, 8'hF0, 1'b1, 23);
        pushBeat(3, 8'hE1, 1'b0, 25);
        pushBeat(3, 8'hE2, 1'b0, 26);
        pushBeat(3, 8'hE3, 1'b1, 27);
        startTest();
        while (cyc < 30) begin
            w_full = (cyc >= 2) && (cyc <= 21);
            sampleOutputs();
            if (cyc == 18) checkOutput("t4_grantLastHold", 32'(grant), 32'b1000);
            if (cyc == 19) checkOutput("t4_released", 32'(grant), 32'd0);
            if (cyc == 20) checkOutput("t4_nextGrant", 32'(grant), 32'b0001);
            applyStimulus();
        end
        w_full = 1'b0;
        checkOutput("t4_drained", 32'(expQ.size()), 32'd0);

        // Reset mid-burst of requester 2 (rr_ptr was 2); arbitration restarts at 0
        $display("[TB] reset mid-burst");
        pushBeat(1, 8'h50, 1'b1, 1);
        pushBeat(2, 8'h70, 1'b0, 3);
        pushBeat(1, 8'h60, 1'b0, 6);
        pushBeat(1, 8'h61, 1'b1, 7);
        pushBeat(2, 8'h71, 1'b0, 9);
        pushBeat(2, 8'h72, 1'b0, 10);
        pushBeat(2, 8'h73, 1'b1, 11);
        startTest();
        while (cyc < 14) begin
            write_error = (cyc < 2);
            rst         = (cyc == 4);
            sampleOutputs();
            if (cyc == 3) checkOutput("t5_errBefore", 32'(err_count), 32'd2);
            if (cyc == 4) checkOutput("t5_wEnInReset", 32'(w_enable), 32'd0);
            if (cyc == 5) checkOutput("t5_grantAfter", 32'(grant), 32'd0);
            if (cyc == 5) checkOutput("t5_busyAfter", 32'(busy), 32'd0);
            if (cyc == 5) checkOutput("t5_errAfter", 32'(err_count), 32'd0);
            if (cyc == 6) checkOutput("t5_restartAt0", 32'(grant), 32'b0010);
            applyStimulus();
        end
        rst         = 1'b0;
        write_error = 1'b0;
        checkOutput("t5_drained", 32'(expQ.size()), 32'd0);

        // Error counter: count then saturate at all-ones
        $display("[TB] error counter saturation");
        pulseErrors(3);
        sampleOutputs();
        checkOutput("t6_errThree", 32'(err_count), 32'd3);
        applyStimulus();
        pulseErrors(11);
        sampleOutputs();
        checkOutput("t6_errNearMax", 32'(err_count), 32'd14);
        applyStimulus();
        pulseErrors(2);
        sampleOutputs();
        checkOutput("t6_errSat", 32'(err_count), 32'd15);
        applyStimulus();
        pulseErrors(1);
        sampleOutputs();
        checkOutput("t6_errNoWrap", 32'(err_count), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
